// File: rtl/priv_pmp_req_gate_if.sv
// Core-side request, PMP query, bus and response signals of priv_pmp_req_gate.
// slave: the gate's view; master: the surrounding core/bus/PMP view.
interface priv_pmp_req_gate_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byte_en;
    logic        req_ren;
    logic        req_wen;
    logic [31:0] pmp_addr;
    logic        pmp_ren;
    logic        pmp_wen;
    logic        pmp_l_fault;
    logic        pmp_s_fault;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic        bus_ren;
    logic        bus_wen;
    logic        bus_busy;
    logic [31:0] bus_rdata;
    logic        rsp_valid;
    logic        rsp_fault;
    logic [3:0]  rsp_cause;
    logic [31:0] rsp_rdata;
    logic [31:0] fault_tval;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_byte_en, req_ren, req_wen,
        input  pmp_l_fault, pmp_s_fault, bus_busy, bus_rdata,
        output req_ready, pmp_addr, pmp_ren, pmp_wen,
        output bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen,
        output rsp_valid, rsp_fault, rsp_cause, rsp_rdata, fault_tval
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_byte_en, req_ren, req_wen,
        output pmp_l_fault, pmp_s_fault, bus_busy, bus_rdata,
        input  req_ready, pmp_addr, pmp_ren, pmp_wen,
        input  bus_addr, bus_wdata, bus_byte_en, bus_ren, bus_wen,
        input  rsp_valid, rsp_fault, rsp_cause, rsp_rdata, fault_tval
    );
endinterface

// File: rtl/priv_pmp_req_gate.sv
// PMP-checked data-access gate: one outstanding request, PMP check, bus, response.
// Define PMP_GATE_TVAL_EN to capture the faulting address on fault_tval.
module priv_pmp_req_gate #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic               CLK,
    input logic               nRST,
    priv_pmp_req_gate_if.slave io
);

    typedef enum logic [2:0] {IDLE, CHECK, BUS, RESP, FAULT} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [3:0]  h_be;
    logic        h_ren;
    logic        h_wen;
    logic [31:0] to_cnt;
    logic [31:0] rdata_q;
    logic [3:0]  cause_q;
    logic        hs;
    logic        timeout;

    assign hs      = io.req_valid && (state == IDLE);
    assign timeout = (TIMEOUT_CYCLES != 0) && io.bus_busy &&
                     (to_cnt == TIMEOUT_CYCLES - 1);

    assign io.pmp_addr    = h_addr;
    assign io.bus_addr    = h_addr;
    assign io.bus_wdata   = h_wdata;
    assign io.bus_byte_en = h_be;
    assign io.rsp_rdata   = rdata_q;
    assign io.rsp_cause   = cause_q;

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        io.req_ready = 1'b0;
        io.pmp_ren   = 1'b0;
        io.pmp_wen   = 1'b0;
        io.bus_ren   = 1'b0;
        io.bus_wen   = 1'b0;
        io.rsp_valid = 1'b0;
        io.rsp_fault = 1'b0;
        unique case (state)
            IDLE: begin
                io.req_ready = 1'b1;
                if (io.req_valid)
                    state_nx = (io.req_ren || io.req_wen) ? CHECK : RESP;
            end
            CHECK: begin
                io.pmp_ren = h_ren;
                io.pmp_wen = h_wen;
                state_nx   = (io.pmp_l_fault || io.pmp_s_fault) ? FAULT : BUS;
            end
            BUS: begin
                io.bus_ren = h_ren;
                io.bus_wen = h_wen;
                if (!io.bus_busy) state_nx = RESP;
                else if (timeout) state_nx = FAULT;
            end
            RESP: begin
                io.rsp_valid = 1'b1;
                state_nx     = IDLE;
            end
            FAULT: begin
                io.rsp_valid = 1'b1;
                io.rsp_fault = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A combined read+write request is handled as a store.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            h_addr  <= '0;
            h_wdata <= '0;
            h_be    <= '0;
            h_ren   <= 1'b0;
            h_wen   <= 1'b0;
            to_cnt  <= '0;
            rdata_q <= '0;
            cause_q <= '0;
        end else begin
            if (hs) begin
                h_addr  <= io.req_addr;
                h_wdata <= io.req_wdata;
                h_be    <= io.req_byte_en;
                h_ren   <= io.req_ren && !io.req_wen;
                h_wen   <= io.req_wen;
                if (!io.req_ren && !io.req_wen) rdata_q <= '0;
            end
            if (state == BUS && io.bus_busy) to_cnt <= to_cnt + 32'd1;
            else                             to_cnt <= '0;
            if (state == BUS && !io.bus_busy)
                rdata_q <= h_ren ? io.bus_rdata : 32'd0;
            if (state_nx == FAULT && state != FAULT)
                cause_q <= h_wen ? 4'd7 : 4'd5;
        end
    end

`ifdef PMP_GATE_TVAL_EN
    logic [31:0] tval_q;

    always_ff @(posedge CLK) begin
        if (!nRST)
            tval_q <= '0;
        else if (state_nx == FAULT && state != FAULT)
            tval_q <= h_addr;
    end

    assign io.fault_tval = tval_q;
`else
    assign io.fault_tval = 32'd0;
`endif

endmodule

// File: tb/tb_priv_pmp_req_gate.sv
// Scoreboard bench for priv_pmp_req_gate (TIMEOUT_CYCLES=4).
// Honours PMP_GATE_TVAL_EN for the expected fault_tval.
module tb_priv_pmp_req_gate;

    localparam int TO = 4;
`ifdef PMP_GATE_TVAL_EN
    localparam bit TVAL = 1'b1;
`else
    localparam bit TVAL = 1'b0;
`endif

    typedef struct {
        logic        fault;
        logic [3:0]  cause;
        logic [31:0] rdata;
        logic [31:0] tval;
        int          due;
        int          nren;
        int          nwen;
        logic        pren;
        logic        pwen;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    priv_pmp_req_gate_if io ();

    priv_pmp_req_gate #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .io   (io.slave)
    );

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          busy_left = 0;
    bit          stuck = 1'b0;
    int          seen_ren = 0;
    int          seen_wen = 0;
    logic        seen_pren = 1'b0;
    logic        seen_pwen = 1'b0;
    logic [3:0]  m_cause = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_tval = '0;
    logic [3:0]  cm_cause = '0;
    logic [31:0] cm_rdata = '0;
    logic [31:0] cm_tval = '0;

    assign io.bus_busy = stuck || (busy_left != 0);

    always @(posedge CLK) cyc++;

    // Response monitor: pops the scoreboard whenever the gate responds.
    always @(negedge CLK) begin
        exp_t e;
        if (nRST) begin
            if (io.bus_ren) seen_ren++;
            if (io.bus_wen) seen_wen++;
            if ((io.bus_ren || io.bus_wen) && busy_left > 0) busy_left--;
            if (io.pmp_ren || io.pmp_wen) begin
                seen_pren = io.pmp_ren;
                seen_pwen = io.pmp_wen;
            end
            if (io.rsp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp cyc=%0d", cyc);
                end else begin
                    e = sb.pop_front();
                    checks += 9;
                    if (cyc !== e.due) begin
                        failures++;
                        $display("FAIL latency got=%0d exp=%0d", cyc, e.due);
                    end
                    if (io.rsp_fault !== e.fault) begin
                        failures++;
                        $display("FAIL rsp_fault got=%b exp=%b", io.rsp_fault, e.fault);
                    end
                    if (io.rsp_cause !== e.cause) begin
                        failures++;
                        $display("FAIL rsp_cause got=%0d exp=%0d", io.rsp_cause, e.cause);
                    end
                    if (io.rsp_rdata !== e.rdata) begin
                        failures++;
                        $display("FAIL rsp_rdata got=%h exp=%h", io.rsp_rdata, e.rdata);
                    end
                    if (io.fault_tval !== e.tval) begin
                        failures++;
                        $display("FAIL fault_tval got=%h exp=%h", io.fault_tval, e.tval);
                    end
                    if (seen_ren !== e.nren) begin
                        failures++;
                        $display("FAIL bus_ren_cycles got=%0d exp=%0d", seen_ren, e.nren);
                    end
                    if (seen_wen !== e.nwen) begin
                        failures++;
                        $display("FAIL bus_wen_cycles got=%0d exp=%0d", seen_wen, e.nwen);
                    end
                    if (seen_pren !== e.pren) begin
                        failures++;
                        $display("FAIL pmp_ren got=%b exp=%b", seen_pren, e.pren);
                    end
                    if (seen_pwen !== e.pwen) begin
                        failures++;
                        $display("FAIL pmp_wen got=%b exp=%b", seen_pwen, e.pwen);
                    end
                    cm_cause = e.cause;
                    cm_rdata = e.rdata;
                    cm_tval  = e.tval;
                end
                seen_ren  = 0;
                seen_wen  = 0;
                seen_pren = 1'b0;
                seen_pwen = 1'b0;
            end else begin
                checks++;
                if (io.rsp_fault !== 1'b0 || io.rsp_cause !== cm_cause ||
                    io.rsp_rdata !== cm_rdata || io.fault_tval !== cm_tval) begin
                    failures++;
                    $display("FAIL hold got=%b/%0d/%h/%h exp=0/%0d/%h/%h",
                             io.rsp_fault, io.rsp_cause, io.rsp_rdata,
                             io.fault_tval, cm_cause, cm_rdata, cm_tval);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic ren, input logic wen,
                          input logic lf, input logic sf,
                          input logic [31:0] rdata, input int nbusy,
                          input bit stk);
        exp_t e;
        int   bc;
        logic eren;
        wait_idle();
        @(negedge CLK);
        checks++;
        if (io.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready got=%b exp=1", io.req_ready);
        end
        io.req_valid   = 1'b1;
        io.req_addr    = addr;
        io.req_wdata   = wdata;
        io.req_byte_en = 4'hF;
        io.req_ren     = ren;
        io.req_wen     = wen;
        io.pmp_l_fault = lf;
        io.pmp_s_fault = sf;
        io.bus_rdata   = rdata;
        busy_left      = nbusy;
        stuck          = stk;
        @(posedge CLK);
        #1;
        io.req_valid = 1'b0;
        eren = ren && !wen;
        bc   = (nbusy < 1) ? 1 : nbusy;
        e.pren = eren;
        e.pwen = wen;
        e.nren = 0;
        e.nwen = 0;
        e.fault = 1'b0;
        if (!ren && !wen) begin
            e.due   = cyc;
            m_rdata = 32'd0;
        end else if (lf || sf) begin
            e.due   = cyc + 1;
            e.fault = 1'b1;
        end else if (stk) begin
            e.due   = cyc + 1 + TO;
            e.fault = 1'b1;
            e.nren  = eren ? TO : 0;
            e.nwen  = wen ? TO : 0;
        end else begin
            e.due   = cyc + 1 + bc;
            e.nren  = eren ? bc : 0;
            e.nwen  = wen ? bc : 0;
            m_rdata = eren ? rdata : 32'd0;
        end
        if (e.fault) begin
            m_cause = wen ? 4'd7 : 4'd5;
            if (TVAL) m_tval = addr;
        end
        e.cause = m_cause;
        e.rdata = m_rdata;
        e.tval  = m_tval;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks += 3;
        if (io.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", io.req_ready);
        end
        if ({io.bus_ren, io.bus_wen, io.pmp_ren, io.pmp_wen,
             io.rsp_valid, io.rsp_fault} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0",
                     {io.bus_ren, io.bus_wen, io.pmp_ren, io.pmp_wen,
                      io.rsp_valid, io.rsp_fault});
        end
        if ({io.pmp_addr, io.bus_addr, io.bus_wdata, io.bus_byte_en,
             io.rsp_cause, io.rsp_rdata, io.fault_tval} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0",
                     io.bus_addr, io.rsp_rdata, io.fault_tval);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_load();
        do_req(32'h8000_0010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
        wait_idle();
    endtask

    task automatic test_store_fault();
        do_req(32'h0000_1000, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        wait_idle();
        do_req(32'h0000_2000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_2222, 0, 1'b0);
        wait_idle();
    endtask

    task automatic test_timeout();
        do_req(32'h4000_0100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA, 0, 1'b1);
        wait_idle();
        do_req(32'h4000_0200, 32'h9, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b1);
        wait_idle();
    endtask

    task automatic test_both_and_nop();
        do_req(32'h0000_3000, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7777_7777, 0, 1'b0);
        do_req(32'h0000_3004, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8888_8888, 0, 1'b0);
        do_req(32'h0000_3008, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE, 3, 1'b0);
        do_req(32'h0000_300C, 32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2, 1'b0);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            do_req($urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                   $urandom, $urandom_range(0, 2), 1'b0);
        end
        wait_idle();
    endtask

    task automatic test_reset_in_bus();
        int n = 0;
        do_req(32'h8000_0400, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 0, 1'b1);
        while (io.bus_ren !== 1'b1 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (io.bus_ren !== 1'b1) begin
            failures++;
            $display("FAIL reach_bus got=%b exp=1", io.bus_ren);
        end
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        sb.delete();
        seen_ren = 0;
        seen_wen = 0;
        seen_pren = 1'b0;
        seen_pwen = 1'b0;
        m_cause = '0;
        m_rdata = '0;
        m_tval  = '0;
        cm_cause = '0;
        cm_rdata = '0;
        cm_tval  = '0;
        stuck = 1'b0;
        busy_left = 0;
        checks += 2;
        if ({io.bus_ren, io.bus_wen, io.rsp_valid} !== 3'b0) begin
            failures++;
            $display("FAIL rst_bus_strobes got=%b exp=000",
                     {io.bus_ren, io.bus_wen, io.rsp_valid});
        end
        if (io.req_ready !== 1'b1 || io.rsp_cause !== 4'd0 ||
            io.rsp_rdata !== 32'd0 || io.fault_tval !== 32'd0) begin
            failures++;
            $display("FAIL rst_bus_state got=%b/%0d/%h/%h exp=1/0/0/0",
                     io.req_ready, io.rsp_cause, io.rsp_rdata, io.fault_tval);
        end
        @(negedge CLK);
        nRST = 1'b1;
        repeat (4) @(negedge CLK);
        do_req(32'h8000_0010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F, 1, 1'b0);
        wait_idle();
    endtask

    initial begin
        io.req_valid   = 1'b0;
        io.req_addr    = '0;
        io.req_wdata   = '0;
        io.req_byte_en = '0;
        io.req_ren     = 1'b0;
        io.req_wen     = 1'b0;
        io.pmp_l_fault = 1'b0;
        io.pmp_s_fault = 1'b0;
        io.bus_rdata   = '0;
        test_reset();
        test_load();
        test_store_fault();
        test_timeout();
        test_both_and_nop();
        test_back_to_back();
        test_reset_in_bus();
        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
